// File: rtl/ads1672_sched_pkg.sv
// Shared state encoding and default sizing for the ADS1672 capture sequencer.
// Imported by the scheduler top; the FIFO is generic and does not depend on it.
package ads1672_sched_pkg;

    localparam int ADS_DATA_WIDTH         = 24;
    localparam int DEFAULT_PERIOD_WIDTH   = 16;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_DATA,
        ST_HOLDOFF
    } sched_state_t;

endpackage

// File: rtl/ads1672_sample_fifo.sv
// Synchronous sample buffer, power-of-two depth, one push and one pop per cycle.
// Latency: a pushed word appears on pop_data/!empty the following cycle.
// Backpressure: a push into a full buffer is dropped (drop=1) unless a pop happens the same cycle.
module ads1672_sample_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  full, push_ok, pop_ok;

    always_comb begin
        full     = (count_q == FULL_COUNT);
        empty    = (count_q == '0);
        pop_ok   = pop && !empty;
        // a full buffer still takes a word when the head leaves in the same cycle
        push_ok  = push && (!full || pop_ok);
        drop     = push && !push_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ads1672_sample_scheduler.sv
// ADS1672 capture sequencer: paced measure pulses, burst counting, sample buffering (watchdog: ADS1672_SCHED_TIMEOUT_EN).
// Latency: measure one cycle after arm; a returned sample is on m_data/m_valid one cycle after adc_valid.
// Backpressure: m_ready stalls the buffer only; conversions keep pace and samples arriving at a full buffer are dropped (overflow).
module ads1672_sample_scheduler
    import ads1672_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = ADS_DATA_WIDTH,
    parameter int PERIOD_WIDTH   = DEFAULT_PERIOD_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [PERIOD_WIDTH-1:0]       period,
    input  logic [7:0]                    burst_len,
    output logic                          measure,
    input  logic                          adc_valid,
    input  logic [DATA_WIDTH-1:0]         adc_data,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          timeout
);

    localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);

    sched_state_t            state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] ivl_q, ivl_d;
    logic [7:0]              smp_q, smp_d;
    logic                    cont_q, cont_d;
    logic                    ovf_q, ovf_d;
    logic                    start, push, ivl_done;
    logic                    fifo_empty, fifo_drop;

`ifdef ADS1672_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        smp_d    = smp_q;
        cont_d   = cont_q;
        start    = 1'b0;
        push     = 1'b0;
        measure  = 1'b0;
        // ivl_q holds cycles elapsed since the last measure, saturating at the period
        ivl_done = (ivl_q >= period_q - P_ONE);
        if (state_q == ST_TRIGGER) begin
            ivl_d = P_ONE;
        end else if (ivl_q < period_q) begin
            ivl_d = ivl_q + P_ONE;
        end else begin
            ivl_d = ivl_q;
        end
`ifdef ADS1672_SCHED_TIMEOUT_EN
        tmo_d = tmo_q;
        wd_d  = (state_q == ST_WAIT_DATA) ? wd_q + WW'(1) : '0;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        start    = 1'b1;
                        state_d  = ST_TRIGGER;
                        period_d = (period == '0) ? P_ONE : period;
                        smp_d    = burst_len;
                        cont_d   = (burst_len == 8'd0);
`ifdef ADS1672_SCHED_TIMEOUT_EN
                        tmo_d    = 1'b0;
`endif
                    end
                end
                ST_TRIGGER: begin
                    measure = 1'b1;
                    state_d = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (adc_valid) begin
                        push = 1'b1;
                        if (!cont_q) begin
                            smp_d = smp_q - 8'd1;
                        end
                        if (!cont_q && smp_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end else if (ivl_done) begin
                            state_d = ST_TRIGGER;
                        end else begin
                            state_d = ST_HOLDOFF;
                        end
                    end
`ifdef ADS1672_SCHED_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = ST_TRIGGER;
                    end
`endif
                end
                ST_HOLDOFF: begin
                    if (ivl_done) begin
                        state_d = ST_TRIGGER;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ovf_d = start ? 1'b0 : (ovf_q | fifo_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= P_ONE;
            ivl_q    <= '0;
            smp_q    <= '0;
            cont_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            ivl_q    <= ivl_d;
            smp_q    <= smp_d;
            cont_q   <= cont_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef ADS1672_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    // no watchdog in this build: timeout can never assert
    assign timeout = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

    ads1672_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (adc_data),
        .pop       (m_ready),
        .pop_data  (m_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign m_valid  = !fifo_empty;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ads1672_sample_scheduler.sv
// Scoreboard bench for the ADS1672 sample scheduler: event-level burst model plus a queue of expected samples.
module tb_ads1672_sample_scheduler;

    localparam int DW    = 24;
    localparam int PW    = 16;
    localparam int DEPTH = 8;

    logic                     clk = 1'b0;
    logic                     rst, arm, abort, adc_valid, m_ready;
    logic [PW-1:0]            period;
    logic [7:0]               burst_len;
    logic [DW-1:0]            adc_data;
    logic                     measure, m_valid, busy, overflow, timeout;
    logic [DW-1:0]            m_data;
    logic [$clog2(DEPTH):0]   fifo_count;

    always #5 clk = ~clk;

    ads1672_sample_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .period     (period),
        .burst_len  (burst_len),
        .measure    (measure),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // reference model: burst in progress, conversion outstanding, earliest next measure
    bit active, outstanding, cont, movf;
    int remaining, per, next_meas, last_meas, mcount;
    logic [DW-1:0] exp_q[$];
    bit resp_pending;
    int resp_at, rd_delay;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic void expire(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
    endfunction

    // stream monitor: every handshake must deliver the oldest expected sample
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) check("stream_extra", m_valid, 0);
            else check("m_data", m_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        bit exp_meas, pop, acc;
        @(negedge clk);
        if (rst) begin
            active = 0; outstanding = 0; movf = 0; mcount = 0;
            resp_pending = 0;
            exp_q.delete();
        end else begin
            exp_meas = active && !outstanding && (cycle == next_meas) && !abort;
            check("measure", measure, exp_meas);
            check("busy", busy, active);
            check("m_valid", m_valid, mcount > 0);
            check("fifo_count", fifo_count, mcount);
            check("overflow", overflow, movf);
            check("timeout", timeout, 0);
            if (measure) begin
                resp_pending = 1;
                resp_at = cycle + rd_delay;
            end
            pop = m_ready && (mcount > 0);
            acc = 0;
            if (abort) begin
                active = 0; outstanding = 0;
            end else if (!active) begin
                if (arm) begin
                    active = 1; outstanding = 0; movf = 0;
                    per = (period == 0) ? 1 : int'(period);
                    remaining = burst_len;
                    cont = (burst_len == 0);
                    next_meas = cycle + 1;
                end
            end else if (exp_meas) begin
                outstanding = 1;
                last_meas = cycle;
            end else if (outstanding && adc_valid) begin
                acc = 1;
                outstanding = 0;
                if (!cont) begin
                    remaining--;
                    if (remaining == 0) active = 0;
                end
                next_meas = (last_meas + per > cycle + 1) ? last_meas + per : cycle + 1;
            end
            if (acc) begin
                if (mcount < DEPTH || pop) begin
                    exp_q.push_back(adc_data);
                    mcount++;
                end else begin
                    movf = 1;
                end
            end
            if (pop) mcount--;
        end
        @(posedge clk);
        #1;
        cycle++;
        arm = 0; abort = 0; adc_valid = 0;
        if (resp_pending && cycle == resp_at) begin
            adc_valid = 1;
            adc_data = DW'($urandom);
            resp_pending = 0;
        end
    endtask

    task automatic start_burst(int p, int len, int d);
        period = PW'(p);
        burst_len = 8'(len);
        rd_delay = d;
        arm = 1;
        tick();
    endtask

    initial begin
        int n;
        rst = 1; arm = 0; abort = 0; adc_valid = 0; adc_data = '0; m_ready = 1;
        period = 16'd10; burst_len = 8'd4; rd_delay = 3;
        repeat (3) tick();
        rst = 0;
        check("rst_measure", measure, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        repeat (3) tick();

        // paced burst, then data-limited burst
        start_burst(10, 4, 3);
        repeat (50) tick();
        start_burst(2, 3, 7);
        repeat (40) tick();

        // stalled consumer: buffer fills, excess dropped, burst still ends
        m_ready = 0;
        start_burst(3, 10, 2);
        repeat (40) tick();
        check("stall_count", fifo_count, DEPTH);
        check("stall_overflow", overflow, 1);
        check("stall_busy", busy, 0);
        m_ready = 1;
        repeat (12) tick();
        start_burst(5, 1, 2);
        repeat (15) tick();

        // continuous burst aborted during holdoff, FIFO retained
        m_ready = 0;
        start_burst(6, 0, 2);
        repeat (12) tick();
        n = 0;
        while (!(active && !outstanding && cycle == last_meas + 4) && n < 40) begin tick(); n++; end
        if (n >= 40) expire("holdoff_wait");
        abort = 1;
        tick();
        check("abort_hold_busy", busy, 0);
        check("abort_hold_kept", fifo_count, mcount);
        repeat (5) tick();
        m_ready = 1;
        repeat (10) tick();

        // abort exactly when the next trigger is due
        start_burst(6, 0, 2);
        repeat (10) tick();
        n = 0;
        while (!(active && !outstanding && cycle == next_meas) && n < 40) begin tick(); n++; end
        if (n >= 40) expire("trigger_wait");
        abort = 1;
        tick();
        repeat (5) tick();

        // abort with a conversion outstanding; its late strobe must be discarded
        start_burst(6, 0, 2);
        repeat (10) tick();
        n = 0;
        while (!(outstanding && cycle == last_meas + 1) && n < 40) begin tick(); n++; end
        if (n >= 40) expire("wait_data_wait");
        abort = 1;
        tick();
        repeat (3) tick();
        adc_valid = 1; adc_data = DW'($urandom);
        tick();
        repeat (4) tick();

        // push and pop together while full: no drop
        m_ready = 0;
        start_burst(4, 9, 2);
        n = 0;
        while (active && n < 80) begin
            m_ready = adc_valid && (mcount == DEPTH);
            tick();
            n++;
        end
        if (active) expire("pushpop_wait");
        check("pushpop_count", fifo_count, DEPTH);
        check("pushpop_overflow", overflow, 0);
        m_ready = 1;
        repeat (12) tick();

        // zero period behaves as one
        start_burst(0, 5, 1);
        repeat (20) tick();
        start_burst(0, 4, 3);
        repeat (25) tick();

        // randomized bursts with stalls, aborts, stray strobes and ignored re-arms
        for (int b = 0; b < 40; b++) begin
            start_burst($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(1, 15));
            n = 0;
            while (active && n < 300) begin
                m_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) == 0 || (cont && n == 120)) abort = 1;
                if ($urandom_range(0, 29) == 0) arm = 1;
                if ($urandom_range(0, 19) == 0) begin
                    period = PW'($urandom_range(0, 12));
                    burst_len = 8'($urandom_range(0, 12));
                end
                if (!adc_valid && !outstanding && $urandom_range(0, 39) == 0) begin
                    adc_valid = 1;
                    adc_data = DW'($urandom);
                end
                tick();
                n++;
            end
            if (active) expire("random_burst_end");
            repeat ($urandom_range(0, 3)) tick();
        end

        // reset in the middle of a burst clears everything
        m_ready = 0;
        start_burst(3, 0, 1);
        repeat (15) tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_busy", busy, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_overflow", overflow, 0);
        m_ready = 1;
        repeat (5) tick();

        repeat (20) tick();
        check("stream_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads1672_sample_scheduler.md
# ads1672_sample_scheduler

Sequencer that drives the ADS1672 EVM capture path: issues `measure` pulses to the ADC reader at a programmable minimum interval, counts a programmed burst of conversions, and buffers returned 24-bit samples in a small FIFO with a valid/ready output stream. It sits between the reader and the downstream sample consumer (DMA/stream logic) and owns all conversion timing.

## Interface
- `DATA_WIDTH`, 24, ADC sample width
- `PERIOD_WIDTH`, 16, width of the trigger-interval register
- `FIFO_DEPTH`, 8, sample buffer entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 4096, watchdog limit in `WAIT_DATA` (used only with macro)
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  one-cycle pulse: start a burst
- `abort`  in  1  level/pulse: stop burst
- `period`  in  PERIOD_WIDTH  minimum cycles from one `measure` to the next; 0 treated as 1
- `burst_len`  in  8  samples per burst; 0 = continuous until `abort`
- `measure`  out  1  one-cycle trigger to ADC reader
- `adc_valid`  in  1  one-cycle strobe: `adc_data` holds a completed conversion
- `adc_data`  in  DATA_WIDTH  sample from reader
- `m_data`  out  DATA_WIDTH  FIFO head
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  consumer accepts head
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy
- `busy`  out  1  state ≠ IDLE
- `overflow`  out  1  sticky: a sample was dropped
- `timeout`  out  1  sticky: watchdog fired (0 without macro)

## Operation
- States: IDLE, TRIGGER, WAIT_DATA, HOLDOFF.
- IDLE: on `arm` latch `period` (0→1) and `burst_len`, clear `overflow`/`timeout`, load sample counter, go TRIGGER. `period`/`burst_len` changes mid-burst ignored.
- TRIGGER: `measure`=1 for exactly this cycle; interval counter reset to 0; go WAIT_DATA.
- Interval counter increments every cycle after TRIGGER, saturates at latched period.
- WAIT_DATA: on `adc_valid` push `adc_data`, decrement sample counter (not if continuous). If counter reaches 0 → IDLE. Else if interval counter ≥ period−1 → TRIGGER, else → HOLDOFF.
- HOLDOFF: when interval counter ≥ period−1 → TRIGGER.
- `abort` has priority over all transitions: next state IDLE, no `measure` that cycle. FIFO contents retained.
- `arm` while busy ignored. `adc_valid` outside WAIT_DATA discarded (no push, no flag).
- FIFO push: accepted if count < FIFO_DEPTH, or count = FIFO_DEPTH with same-cycle pop. Otherwise sample dropped, `overflow` set; sample counter still decrements (burst completes on time).
- Pop when `m_valid && m_ready`. Push and pop same cycle: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset: state IDLE, `measure`=0, `busy`=0, `m_valid`=0, `fifo_count`=0, `overflow`=0, `timeout`=0, `m_data` don't-care (0 in practice).
- `arm` at cycle n → `busy` and TRIGGER at n+1, `measure` high at n+1.
- Consecutive `measure` pulses spaced ≥ period cycles; exactly period when `adc_valid` arrives ≤ period−2 cycles after `measure`.
- Pushed sample visible on `m_data`/`m_valid` the cycle after `adc_valid`.
- Final `adc_valid` of burst at n → `busy`=0 at n+1.
- `rst` mid-burst: all state and FIFO cleared next cycle.

## Configuration
- `ADS1672_SCHED_TIMEOUT_EN` defined: WAIT_DATA counts cycles; at TIMEOUT_CYCLES without `adc_valid`, set `timeout`, go TRIGGER (retry; sample counter not decremented). Counter resets on every TRIGGER.
- Undefined: WAIT_DATA waits indefinitely; `timeout` tied 0; no watchdog counter logic.

## Structure
- Package `ads1672_sched_pkg`: state enum `sched_state_t`, `ADS_DATA_WIDTH`=24, default period/depth constants.
- Sub-module `ads1672_sample_fifo`: synchronous FIFO (push/pop/count/full/empty, dropped-push indication); scheduler FSM and counters in top.

## Test plan
- `period`=10, `burst_len`=4, reader answers 3 cycles after `measure` → 4 `measure` pulses 10 cycles apart, samples A,B,C,D out in order, `busy` low 1 cycle after 4th `adc_valid`.
- `period`=2, reader answers 7 cycles after `measure` → pulses 8 cycles apart (data-limited), no overflow.
- `m_ready`=0, `burst_len`=10, DEPTH=8 → `fifo_count`=8, `overflow`=1, burst still ends after 10 valids; first 8 samples intact; next `arm` clears `overflow`.
- `burst_len`=0, assert `abort` in HOLDOFF and in the cycle TRIGGER would occur → no `measure`, IDLE next cycle, FIFO kept; late `adc_valid` not pushed.
- Push+pop simultaneously at count=8 → count stays 8, no overflow; `period`=0 → spacing as period=1.
- With `ADS1672_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=16, reader silent → `timeout`=1 at 16 cycles, re-`measure`; without macro, `busy` stays 1, `timeout`=0.
